// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one bit per cycle (shift-add multiply,
// restoring divide). Operands are converted to magnitudes and sign-corrected at the end.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_RUN,
        S_DIV_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_opnd;
    logic [2*XLEN-1:0] r_prod;
    logic              r_sign_a;
    logic              r_sign_b;
    logic              r_fast;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_result;

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Operand decode at request time
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_val;
    logic            w_accept;

    assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign w_b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign w_sa       = w_a_signed & op_a[XLEN-1];
    assign w_sb       = w_b_signed & op_b[XLEN-1];
    assign w_mag_a    = cneg(op_a, w_sa);
    assign w_mag_b    = cneg(op_b, w_sb);
    assign w_div_zero = (op_b == '0);
    assign w_ovf      = ~funct3[0] & (op_a == MIN_NEG) & (op_b == '1);
    assign w_fast     = funct3[2] & (w_div_zero | w_ovf);
    assign w_accept   = (r_state == S_IDLE) & start & ~flush;

    always_comb begin
        w_fast_val = '0;
        if (w_div_zero) begin
            w_fast_val = funct3[1] ? op_a : '1;
        end else begin
            w_fast_val = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // Iteration datapath: r_prod holds {acc, multiplier} or {rem, quot}
    logic              w_cnt_end;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_step;
    logic [XLEN:0]     w_div_sh;
    logic [XLEN:0]     w_div_trial;
    logic              w_div_ok;
    logic [2*XLEN-1:0] w_div_step;

    assign w_cnt_end   = (r_cnt == CNT_W'(XLEN));
    assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_step  = {w_mul_sum, r_prod[XLEN-1:1]};
    assign w_div_sh    = r_prod[2*XLEN-1:XLEN-1];
    assign w_div_trial = w_div_sh - {1'b0, r_opnd};
    assign w_div_ok    = ~w_div_trial[XLEN];
    assign w_div_step  = {(w_div_ok ? w_div_trial[XLEN-1:0] : w_div_sh[XLEN-1:0]),
                          r_prod[XLEN-2:0], w_div_ok};

    // Final sign correction and result selection
    logic [2*XLEN-1:0] w_mul_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_final;
    logic              w_finish;

    assign w_mul_fix  = cneg_wide(r_prod, r_sign_a ^ r_sign_b);
    assign w_quot_fix = cneg(r_prod[XLEN-1:0], r_sign_a ^ r_sign_b);
    assign w_rem_fix  = cneg(r_prod[2*XLEN-1:XLEN], r_sign_a);

    always_comb begin
        w_final = '0;
        if (!r_funct3[2]) begin
            w_final = (r_funct3[1:0] == 2'b00) ? w_mul_fix[XLEN-1:0] : w_mul_fix[2*XLEN-1:XLEN];
        end else if (r_fast) begin
            w_final = r_prod[XLEN-1:0];
        end else begin
            w_final = r_funct3[1] ? w_rem_fix : w_quot_fix;
        end
    end

    assign w_finish = ((r_state == S_MUL_RUN) || (r_state == S_DIV_RUN)) && (w_next == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        stall  = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = start;
                if (start && !flush) begin
                    w_next = funct3[2] ? S_DIV_RUN : S_MUL_RUN;
                end
            end
            S_MUL_RUN: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (flush) begin
                    w_next = S_IDLE;
                end else if (w_cnt_end) begin
                    w_next = S_DONE;
                end
            end
            S_DIV_RUN: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_fast || w_cnt_end) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Fast-path divides park their answer in the low word and skip iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3 <= '0;
            r_opnd   <= '0;
            r_prod   <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_fast   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_funct3 <= funct3;
                r_sign_a <= w_sa;
                r_sign_b <= w_sb;
                r_fast   <= w_fast;
                r_cnt    <= '0;
                if (!funct3[2]) begin
                    r_opnd <= w_mag_a;
                    r_prod <= {{XLEN{1'b0}}, w_mag_b};
                end else if (w_fast) begin
                    r_opnd <= w_mag_b;
                    r_prod <= {{XLEN{1'b0}}, w_fast_val};
                end else begin
                    r_opnd <= w_mag_b;
                    r_prod <= {{XLEN{1'b0}}, w_mag_a};
                end
            end else if (r_state == S_MUL_RUN && !flush && !w_cnt_end) begin
                r_prod <= w_mul_step;
                r_cnt  <= r_cnt + 1'b1;
            end else if (r_state == S_DIV_RUN && !flush && !r_fast && !w_cnt_end) begin
                r_prod <= w_div_step;
                r_cnt  <= r_cnt + 1'b1;
            end
            if (w_finish) begin
                r_result <= w_final;
            end
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed RV32M cases, fast paths, start/flush/reset
// handling and randomized operations against an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] last_exp = '0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sp;
        logic [63:0] up;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        case (f)
            3'd0: begin sp = sa * sb; return sp[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
                sp = sa % sb; return sp[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == MIN_NEG && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MIN_NEG;
            default: return $urandom;
        endcase
    endfunction

    // Issues one request and waits (bounded) for done; lat=40 means it never came.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stall_cyc,
                          output logic stall_at_done);
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        stall_cyc = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (stall === 1'b1) stall_cyc++;
            @(negedge clk);
            lat++;
        end
        res = result;
        stall_at_done = stall;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b stall=%b result=%h, required 0/0/0/00000000",
                     busy, done, stall, result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul_directed();
        logic [31:0] res;
        int lat, sc;
        logic sd;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, sc, sd);
        n_cmp++;
        if (res !== 32'hFFFF_FFEB) begin
            n_fail++; $display("FAIL mul_7x-3: got %h required FFFFFFEB", res);
        end
        n_cmp++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL mul_latency: got %0d required 33", lat);
        end
        n_cmp++;
        if (sc !== 33 || sd !== 1'b0) begin
            n_fail++; $display("FAIL mul_stall: high %0d cycles, at done %b; required 33, 0", sc, sd);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL done_pulse_width: done=%b busy=%b after done cycle, required 0/0", done, busy);
        end
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, sc, sd);
        n_cmp++;
        if (res !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL mulhu_max: got %h required FFFFFFFE", res);
        end
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, sc, sd);
        n_cmp++;
        if (res !== 32'h0000_0000) begin
            n_fail++; $display("FAIL mulh_m1xm1: got %h required 00000000", res);
        end
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, res, lat, sc, sd);
        n_cmp++;
        if (res !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL mulhsu_m1x2: got %h required FFFFFFFF", res);
        end
    endtask

    task automatic test_div_directed();
        logic [31:0] res;
        int lat, sc;
        logic sd;
        logic [2:0]  fs [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] ex [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            run_op(fs[i], as[i], bs[i], res, lat, sc, sd);
            n_cmp++;
            if (res !== ex[i] || lat !== 33) begin
                n_fail++;
                $display("FAIL div_directed[%0d]: got %h lat %0d, required %h lat 33", i, res, lat, ex[i]);
            end
        end
        last_exp = ex[3];
    endtask

    task automatic test_fastpath();
        logic [31:0] res;
        int lat, sc;
        logic sd;
        logic [2:0]  fs [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] as [4] = '{32'd5, 32'd5, MIN_NEG, MIN_NEG};
        logic [31:0] bs [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'd5, MIN_NEG, 32'd0};
        for (int i = 0; i < 4; i++) begin
            run_op(fs[i], as[i], bs[i], res, lat, sc, sd);
            n_cmp++;
            if (res !== ex[i] || lat !== 1 || sd !== 1'b0) begin
                n_fail++;
                $display("FAIL fastpath[%0d]: got %h lat %0d stall@done %b, required %h lat 1 stall 0",
                         i, res, lat, sd, ex[i]);
            end
        end
        last_exp = ex[3];
    endtask

    task automatic test_random();
        logic [31:0] res, a, b, exp_r;
        logic [2:0]  f;
        int lat, sc, exp_l;
        logic sd;
        for (int i = 0; i < 48; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            exp_r = ref_model(f, a, b);
            exp_l = ref_latency(f, a, b);
            run_op(f, a, b, res, lat, sc, sd);
            n_cmp++;
            if (res !== exp_r || lat !== exp_l) begin
                n_fail++;
                $display("FAIL random[%0d] f=%0d a=%h b=%h: got %h lat %0d, required %h lat %0d",
                         i, f, a, b, res, lat, exp_r, exp_l);
            end
            last_exp = exp_r;
        end
    endtask

    task automatic test_start_ignored();
        int k;
        logic [31:0] exp_r;
        exp_r = ref_model(3'd0, 32'h0000_1234, 32'h0000_5678);
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'h0000_1234; op_b = 32'h0000_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (k < 10) begin @(negedge clk); k++; end
        funct3 = 3'd3; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k++;
        while (done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        n_cmp++;
        if (result !== exp_r || k !== 33) begin
            n_fail++;
            $display("FAIL start_ignored: got %h at cycle %0d, required %h at 33", result, k, exp_r);
        end
        last_exp = exp_r;
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: busy=%b required 0", busy);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0 || result !== last_exp) begin
            n_fail++;
            $display("FAIL flush_no_done: %0d done pulses, result %h; required 0, %h", seen, result, last_exp);
        end
        funct3 = 3'd5; op_a = 32'd9; op_b = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0 || result !== last_exp) begin
            n_fail++;
            $display("FAIL flush_with_start: %0d busy/done cycles, result %h; required 0, %h", seen, result, last_exp);
        end
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] res;
        int lat, sc, seen;
        logic sd;
        @(negedge clk);
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'hFFFF_FFFD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_div: busy=%b done=%b result=%h, required 0/0/00000000", busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL reset_no_done: %0d done pulses, required 0", seen);
        end
        run_op(3'd6, 32'd1000, 32'hFFFF_FFFD, res, lat, sc, sd);
        n_cmp++;
        if (res !== ref_model(3'd6, 32'd1000, 32'hFFFF_FFFD) || lat !== 33) begin
            n_fail++; $display("FAIL after_reset_rem: got %h lat %0d, required 00000001 lat 33", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_mul_directed();
        test_div_directed();
        test_fastpath();
        test_random();
        test_start_ignored();
        test_flush();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
